// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD counter sequencer.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // A nibble is a legal BCD digit when it is 0..9.
  function automatic logic nib_valid(input logic [3:0] n);
    return (n <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single 0..9 BCD digit with clear, load and count-enable (that priority).
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  input  logic       ld,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       is9
);

  logic [3:0] q_q, q_d;

  // Next digit value; an out-of-range load nibble is written as 0.
  always_comb begin
    q_d = q_q;
    if (clr)
      q_d = 4'd0;
    else if (ld)
      q_d = nib_valid(d) ? d : 4'd0;
    else if (en)
      q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
  end

  // Digit register, async active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_q <= 4'd0;
    else        q_q <= q_d;
  end

  assign q   = q_q;
  assign is9 = (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_counter_ctrl.sv
// Sequencer for a chain of BCD digits: FSM, limit compare, priority decode,
// carry chaining and registered done/overflow pulses.
module bcd_counter_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  input  logic [4*DIGITS-1:0] limit,
  input  logic                tick,
  output logic [4*DIGITS-1:0] count,
  output logic [1:0]          state,
  output logic                running,
  output logic                done,
  output logic                overflow
);

  state_e state_q, state_d;
  logic   done_q, done_d;
  logic   ovf_q, ovf_d;
  logic   running_q;

  logic                    dig_clr, dig_ld, incr;
  logic                    limit_ok, at_limit;
  logic [DIGITS-1:0]       is9;
  logic [DIGITS-1:0]       carry;
  logic [DIGITS-1:0][3:0]  q;

  assign count = q;

  // A limit holding any non-BCD nibble can never match, so the count free-runs.
  always_comb begin
    limit_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (!nib_valid(limit[4*i +: 4])) limit_ok = 1'b0;
  end

  assign at_limit = limit_ok && (count == limit);

  // Priority decode clear > load > stop > start > tick, plus FSM next state.
  always_comb begin
    state_d = state_q;
    dig_clr = 1'b0;
    dig_ld  = 1'b0;
    incr    = 1'b0;
    done_d  = 1'b0;
    ovf_d   = 1'b0;
    if (clear) begin
      dig_clr = 1'b1;
      state_d = ST_IDLE;
    end else if (load && state_q != ST_RUN) begin
      dig_ld = 1'b1;
      if (state_q == ST_DONE) state_d = ST_IDLE;
    end else if (stop) begin
      if (state_q == ST_RUN) state_d = ST_PAUSE;
    end else if (start && state_q != ST_RUN) begin
      // Restarting from DONE begins a fresh count.
      if (state_q == ST_DONE) dig_clr = 1'b1;
      state_d = ST_RUN;
    end else if (tick && state_q == ST_RUN) begin
      if (at_limit) begin
        done_d = 1'b1;
        if (AUTO_RELOAD) dig_clr = 1'b1;
        else             state_d = ST_DONE;
      end else begin
        incr  = 1'b1;
        ovf_d = &is9;
      end
    end
  end

  // Carry chain: digit i steps only when all lower digits are 9.
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    if (i == 0) begin : g_c0
      assign carry[i] = incr;
    end else begin : g_ci
      assign carry[i] = carry[i-1] & is9[i-1];
    end

    bcd_digit u_dig (
      .clk   (clk),
      .reset (reset),
      .en    (carry[i]),
      .clr   (dig_clr),
      .ld    (dig_ld),
      .d     (load_value[4*i +: 4]),
      .q     (q[i]),
      .is9   (is9[i])
    );
  end

  // State and pulse registers, async active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      running_q <= (state_d == ST_RUN);
    end
  end

  assign state    = state_q;
  assign running  = running_q;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule

// File: doc/bcd_counter_ctrl.md
# bcd_counter_ctrl

Sequencer for a chain of BCD digit counters: starts, pauses, clears, presets and terminates a DIGITS-wide decimal count driven by an external `tick` strobe. It sits between the user controls (buttons or CPU strobes) and the display path. It owns the per-digit enables and carry chaining, and it flags terminal count and overflow.

## Interface
- `DIGITS`, 4: number of BCD digits; `count` is 4*DIGITS bits wide, digit 0 in bits [3:0].
- `AUTO_RELOAD`, 0: 1 means that on reaching `limit` the count returns to 0 and the counter keeps running. 0 means it halts in DONE.

- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `start` in 1: run request (level sampled each cycle).
- `stop` in 1: pause request.
- `clear` in 1: force count to 0 and return to IDLE.
- `load` in 1: preset count from `load_value`.
- `load_value` in 4*DIGITS: preset value, BCD.
- `limit` in 4*DIGITS: terminal value, BCD.
- `tick` in 1: count-enable strobe, one increment per high cycle.
- `count` out 4*DIGITS: current BCD count.
- `state` out 2: IDLE=00, RUN=01, PAUSE=10, DONE=11.
- `running` out 1: high when `state` is RUN.
- `done` out 1: one-cycle pulse on terminal count.
- `overflow` out 1: one-cycle pulse when the count wraps from all-9s to 0.

## Operation
- Reset (`reset`=0) sets `count`=0, `state`=IDLE, and `running`, `done`, `overflow`=0.
- Input priority per cycle, highest first: `clear`, `load`, `stop`, `start`, `tick`.
- `clear` is honoured in any state: `count`←0, `state`←IDLE, and `tick` is ignored that cycle.
- `load`:
  - Honoured in IDLE, PAUSE and DONE; ignored in RUN.
  - `count`←`load_value`, with any nibble >9 written as 0.
  - `state` is unchanged, except DONE→IDLE.
- FSM transitions:
  - IDLE: `start` → RUN.
  - RUN: `stop` → PAUSE, and `tick` is ignored that cycle. Otherwise `tick` increments the count.
  - PAUSE: `start` → RUN. `tick` is ignored.
  - DONE: `start` → RUN with `count`←0. `tick` is ignored.
  - Simultaneous `start` and `stop` resolves to stop: IDLE stays IDLE, RUN goes to PAUSE.
- Increment, on `tick` in RUN:
  - If `count`==`limit`: `done`=1 next cycle. With AUTO_RELOAD=1, `count`←0 and the FSM stays in RUN. With AUTO_RELOAD=0, `count` holds and `state`←DONE.
  - Otherwise the count increments in BCD. Digit i rolls 9→0 and carries into digit i+1 only when digits 0..i are all 9, so the ripple resolves within one cycle.
  - If `count` was all 9s and ≠`limit`, `count`←0 and `overflow`=1 next cycle.
- A `limit` containing any nibble >9 never matches, so the counter free-runs and wraps.

## Timing
- All outputs are registered and update on the `clk` edge that samples the causing input.
- `count` reflects an accepted `tick` one cycle later, and `done`/`overflow` assert in that same cycle for exactly one cycle.
- With `tick` held high in RUN, the counter advances every cycle.
- A `limit` or `load_value` change takes effect at the next sampling edge.
- Reset asserted mid-count clears outputs asynchronously. After deassertion the first edge sees IDLE with `count`=0.

## Structure
- Shared package `bcd_pkg`:
  - State enum: IDLE, RUN, PAUSE, DONE.
  - Constant BCD_MAX=4'd9.
  - Nibble-valid function.
- One sub-module `bcd_digit`:
  - Inputs: `clk`, `reset`, `en`, `clr`, `ld`, `d[3:0]`.
  - Outputs: `q[3:0]`, `is9`.
  - 0–9 counter, instantiated DIGITS times.
  - Carry enable for digit i = incr AND digits 0..i-1 all `is9`.
- Top level: FSM, limit compare, priority decode and pulse registers.

## Test plan
1. Reset, then `start` and 15 consecutive `tick`s (DIGITS=2, `limit`=99, AUTO_RELOAD=0) → `count`=0x15 (BCD 15) and `state`=RUN.
2. `load_value`=0x98 in IDLE, `start`, then 2 `tick`s with `limit`=0x50 → `count` goes 99 then 00, and `overflow` pulses for exactly one cycle after the second tick.
3. `limit`=0x05 and 6 `tick`s:
   - AUTO_RELOAD=0 → `count` holds at 05, `state`=DONE, one `done` pulse.
   - AUTO_RELOAD=1 → `count`=00, still RUN.
4. RUN at 07, then `stop` and `tick` in the same cycle → `state`=PAUSE and `count`=07. `start` → RUN, and the next `tick` gives 08.
5. `clear`, `load` and `start` together in PAUSE with `count`=42 → `count`=00 and `state`=IDLE.
6. `reset` low mid-RUN at `count`=0x37 between edges → outputs drop to 0 and IDLE immediately, without waiting for `clk`.
